comm_master_nbyte: RTL and testbench
====================================

Name: comm_master_nbyte

Overview:
- Parametrised successor to the two-byte command master.
- Serialises a CMD_BYTES-wide command MSB-first into a byte-level UART transceiver.
- Then collects a RSP_BYTES-wide response, also MSB-first, under a response timeout.
- Sits between the test/host controller and the UART, and drives the UART's trmt/tx_data/clr_rdy directly.

Parameters:
- CMD_BYTES, 2, command length in bytes (>=1).
- RSP_BYTES, 1, response length in bytes (>=1).
- TIMEOUT_CYC, 1_000_000, clocks allowed between response bytes (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- snd_cmd  in  1  one-cycle request; accepted only when busy=0
- cmd  in  8*CMD_BYTES  command, sampled on accepted snd_cmd
- trmt  out  1  one-cycle transmit strobe to UART
- tx_data  out  8  byte to transmit; valid while trmt=1
- tx_done  in  1  one-cycle UART byte-sent pulse
- rx_rdy  in  1  UART byte-available level; held until clr_rdy
- rx_data  in  8  UART received byte
- clr_rdy  out  1  consume received byte
- busy  out  1  transaction in progress
- cmd_cmplt  out  1  one-cycle pulse: last command byte sent
- resp_cmplt  out  1  one-cycle pulse: full response captured
- timeout  out  1  one-cycle pulse: response timed out
- resp  out  8*RSP_BYTES  assembled response

Behaviour:
- Reset values: trmt, clr_rdy, busy, cmd_cmplt, resp_cmplt and timeout are 0; tx_data=0; resp=0. All counters and shift registers clear; state=IDLE. Reset mid-transaction aborts immediately and emits no pulses.
- States: IDLE, LOAD, TX_WAIT, RX_WAIT.
- IDLE:
  - On snd_cmd, latch cmd into the command shift register, clear byte count, go to LOAD.
  - busy=1 from the next cycle.
- LOAD (one cycle):
  - trmt=1 and tx_data = top byte of the shift register. tx_data is registered, so it is stable in this cycle.
  - Go to TX_WAIT.
- TX_WAIT, on tx_done:
  - If bytes sent < CMD_BYTES: shift left 8, go to LOAD.
  - Otherwise: cmd_cmplt=1 for one cycle, clear resp to 0, load the timeout counter, go to RX_WAIT.
- Timing:
  - Accepted snd_cmd at cycle 0 gives trmt at cycle 1.
  - tx_done at cycle k gives the next trmt at k+2.
  - The last tx_done at cycle k gives cmd_cmplt at k+1.
- RX_WAIT, on rx_rdy=1:
  - clr_rdy=1 in the same cycle (combinational on state & rx_rdy); the UART drops rx_rdy the following cycle.
  - resp <= {resp[8*RSP_BYTES-9:0], rx_data}; the first received byte ends in the MSB.
  - Byte count increments and the timeout counter reloads.
  - On the RSP_BYTES-th byte: resp_cmplt=1 the next cycle, busy=0 the next cycle, go to IDLE.
- Timeout:
  - The counter counts every RX_WAIT cycle without rx_rdy.
  - On reaching TIMEOUT_CYC-1: timeout=1 for one cycle, go to IDLE, no resp_cmplt.
  - resp keeps its partial contents.
  - If rx_rdy and expiry coincide, the byte wins: it is captured and the counter reloads.
- Stale bytes: rx_rdy in IDLE, LOAD or TX_WAIT is discarded, with clr_rdy=1 in that cycle.
- Pulse exclusivity: resp_cmplt and timeout are never high together.
- snd_cmd while busy=1 is ignored, with no latch and no error.
- snd_cmd in the same cycle that resp_cmplt or timeout pulses (state already IDLE) is accepted.
- resp holds its value until the next cmd_cmplt clears it.

Decomposition:
- Package comm_pkg holds:
  - the state_t enum;
  - helper constants CMD_CNT_W=$clog2(CMD_BYTES+1), RSP_CNT_W=$clog2(RSP_BYTES+1), TO_W=$clog2(TIMEOUT_CYC).
- One sub-module, comm_timeout: loadable down-counter with load, en, expired, and parameter TIMEOUT_CYC.
- The FSM and shift registers stay in comm_master_nbyte.

Test Plan:
- Defaults, cmd=16'hA55A, UART model returns 8'h3C:
  - tx_data sequence A5 then 5A, each with a single-cycle trmt;
  - cmd_cmplt one cycle after the second tx_done;
  - resp=8'h3C with resp_cmplt 1 cycle after rx_rdy;
  - clr_rdy high exactly 1 cycle.
- CMD_BYTES=3, RSP_BYTES=2, cmd=24'h123456, response bytes AB, CD:
  - tx order 12, 34, 56;
  - resp=16'hABCD;
  - busy falls with resp_cmplt+1.
- TIMEOUT_CYC=20, no response byte:
  - timeout pulses exactly 20 cycles after cmd_cmplt;
  - no resp_cmplt;
  - busy=0 next cycle.
- Second snd_cmd (16'hFFFF) during TX_WAIT:
  - ignored, so only the original bytes are sent;
  - a new snd_cmd on the resp_cmplt cycle is accepted, with trmt on the following cycle.
- rx_rdy with 8'h77 asserted while in TX_WAIT:
  - clr_rdy pulses and the byte is discarded;
  - the later response 8'h3C yields resp=8'h3C.
- rst_n dropped mid-TX_WAIT:
  - all outputs return to 0 asynchronously;
  - after release, a fresh transaction completes normally.

Source files
------------

// File: rtl/comm_pkg.sv
`default_nettype none
// ==========================================================================
// comm_pkg : shared types and width helpers for the N-byte command master
// Rev 1.0
// ==========================================================================
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    TX_WAIT = 2'd2,
    RX_WAIT = 2'd3
  } state_t;

  // Widths depend on the instantiating module's parameters, so they are
  // provided as constant functions rather than fixed localparams.
  function automatic int cmd_cnt_w(input int cmd_bytes);
    return $clog2(cmd_bytes + 1);
  endfunction

  function automatic int rsp_cnt_w(input int rsp_bytes);
    return $clog2(rsp_bytes + 1);
  endfunction

  function automatic int to_w(input int timeout_cyc);
    return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/comm_timeout.sv
`default_nettype none
// ==========================================================================
// comm_timeout : loadable down-counter flagging an expired response window
// Rev 1.0
// ==========================================================================
module comm_timeout
  import comm_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int              TO_W   = to_w(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] RELOAD = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - TO_W'(1);
    end
  end

  // Expiry is the TIMEOUT_CYC-th enabled cycle after a load.
  assign expired = en && (count == '0);

endmodule
`default_nettype wire

// File: rtl/comm_master_nbyte.sv
`default_nettype none
// ==========================================================================
// comm_master_nbyte : sends a CMD_BYTES command over a byte UART, then
// collects a RSP_BYTES response under a per-byte timeout.  Rev 1.0
// ==========================================================================
module comm_master_nbyte
  import comm_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int RSP_BYTES   = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   snd_cmd,
  input  logic [8*CMD_BYTES-1:0] cmd,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rdy,
  output logic                   busy,
  output logic                   cmd_cmplt,
  output logic                   resp_cmplt,
  output logic                   timeout,
  output logic [8*RSP_BYTES-1:0] resp
);

  localparam int CMD_W     = 8 * CMD_BYTES;
  localparam int RSP_W     = 8 * RSP_BYTES;
  localparam int CMD_CNT_W = cmd_cnt_w(CMD_BYTES);
  localparam int RSP_CNT_W = rsp_cnt_w(RSP_BYTES);

  state_t                 state, state_nxt;
  logic [CMD_W-1:0]       shreg;
  logic [7:0]             tx_byte;
  logic                   gap;
  logic [CMD_CNT_W-1:0]   sent_cnt;
  logic [RSP_CNT_W-1:0]   rx_cnt;
  logic [RSP_W-1:0]       resp_q;
  logic                   cmd_cmplt_q, resp_cmplt_q, timeout_q;

  logic accept, tx_more, tx_last, reload_byte;
  logic rx_take, rx_last, rx_expire;
  logic to_load, to_en, to_expired;

  comm_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (to_load),
    .en     (to_en),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    tx_more     = 1'b0;
    tx_last     = 1'b0;
    reload_byte = 1'b0;
    rx_take     = 1'b0;
    rx_last     = 1'b0;
    rx_expire   = 1'b0;
    case (state)
      IDLE: begin
        if (snd_cmd) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        // After a shift, one cycle refreshes the registered tx byte.
        if (gap) begin
          reload_byte = 1'b1;
          state_nxt   = LOAD;
        end else if (tx_done) begin
          if (sent_cnt == CMD_CNT_W'(CMD_BYTES - 1)) begin
            tx_last   = 1'b1;
            state_nxt = RX_WAIT;
          end else begin
            tx_more = 1'b1;
          end
        end
      end
      RX_WAIT: begin
        // A byte arriving on the expiry cycle takes priority.
        if (rx_rdy) begin
          rx_take = 1'b1;
          if (rx_cnt == RSP_CNT_W'(RSP_BYTES - 1)) begin
            rx_last   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (to_expired) begin
          rx_expire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      tx_byte      <= '0;
      gap          <= 1'b0;
      sent_cnt     <= '0;
      rx_cnt       <= '0;
      resp_q       <= '0;
      cmd_cmplt_q  <= 1'b0;
      resp_cmplt_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cmd_cmplt_q  <= tx_last;
      resp_cmplt_q <= rx_last;
      timeout_q    <= rx_expire;
      if (accept) begin
        shreg    <= cmd;
        tx_byte  <= cmd[CMD_W-1 -: 8];
        sent_cnt <= '0;
        gap      <= 1'b0;
      end
      if (tx_more) begin
        shreg    <= shreg << 8;
        sent_cnt <= sent_cnt + CMD_CNT_W'(1);
        gap      <= 1'b1;
      end
      if (reload_byte) begin
        tx_byte <= shreg[CMD_W-1 -: 8];
        gap     <= 1'b0;
      end
      if (tx_last) begin
        resp_q <= '0;
        rx_cnt <= '0;
      end
      if (rx_take) begin
        resp_q <= (resp_q << 8) | RSP_W'(rx_data);
        rx_cnt <= rx_cnt + RSP_CNT_W'(1);
      end
    end
  end

  assign to_load = tx_last | rx_take;
  assign to_en   = (state == RX_WAIT) & ~rx_rdy;

  // Bytes are consumed in every state; only RX_WAIT keeps them.
  assign clr_rdy    = rx_rdy & rst_n;
  assign trmt       = (state == LOAD);
  assign tx_data    = tx_byte;
  assign busy       = (state != IDLE);
  assign cmd_cmplt  = cmd_cmplt_q;
  assign resp_cmplt = resp_cmplt_q;
  assign timeout    = timeout_q;
  assign resp       = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_comm_master_nbyte.sv
`default_nettype none
// ==========================================================================
// tb_comm_master_nbyte : randomized bench with a transaction-level model,
// driving a 2/1-byte and a 3/2-byte instance through a shared UART model.
// ==========================================================================
module tb_comm_master_nbyte;

  localparam int TA = 20;
  localparam int TB = 25;

  logic        clk = 1'b0;
  logic        rst_n, snd_cmd, tx_done, rx_rdy, sel;
  logic [23:0] cmd_bus;
  logic [7:0]  rx_data;

  logic        trmt_a, clr_a, busy_a, cc_a, rc_a, to_a;
  logic [7:0]  txd_a, resp_a;
  logic        trmt_b, clr_b, busy_b, cc_b, rc_b, to_b;
  logic [7:0]  txd_b;
  logic [15:0] resp_b;

  logic        trmt_m, clr_m, busy_m, cc_m, rc_m, to_m;
  logic [7:0]  txd_m;
  logic [15:0] resp_m;

  logic [7:0]  rsp_bytes [2];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  comm_master_nbyte #(.CMD_BYTES(2), .RSP_BYTES(1), .TIMEOUT_CYC(TA)) dut_a (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd & ~sel), .cmd(cmd_bus[15:0]),
    .trmt(trmt_a), .tx_data(txd_a), .tx_done(tx_done & ~sel),
    .rx_rdy(rx_rdy & ~sel), .rx_data(rx_data), .clr_rdy(clr_a), .busy(busy_a),
    .cmd_cmplt(cc_a), .resp_cmplt(rc_a), .timeout(to_a), .resp(resp_a)
  );

  comm_master_nbyte #(.CMD_BYTES(3), .RSP_BYTES(2), .TIMEOUT_CYC(TB)) dut_b (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd & sel), .cmd(cmd_bus),
    .trmt(trmt_b), .tx_data(txd_b), .tx_done(tx_done & sel),
    .rx_rdy(rx_rdy & sel), .rx_data(rx_data), .clr_rdy(clr_b), .busy(busy_b),
    .cmd_cmplt(cc_b), .resp_cmplt(rc_b), .timeout(to_b), .resp(resp_b)
  );

  assign trmt_m = sel ? trmt_b : trmt_a;
  assign clr_m  = sel ? clr_b  : clr_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign cc_m   = sel ? cc_b   : cc_a;
  assign rc_m   = sel ? rc_b   : rc_a;
  assign to_m   = sel ? to_b   : to_a;
  assign txd_m  = sel ? txd_b  : txd_a;
  assign resp_m = sel ? resp_b : {8'h00, resp_a};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_trmt"},       32'(trmt_m), 32'd0);
    check_eq({tag, "_clr_rdy"},    32'(clr_m),  32'd0);
    check_eq({tag, "_busy"},       32'(busy_m), 32'd0);
    check_eq({tag, "_cmd_cmplt"},  32'(cc_m),   32'd0);
    check_eq({tag, "_resp_cmplt"}, 32'(rc_m),   32'd0);
    check_eq({tag, "_timeout"},    32'(to_m),   32'd0);
    check_eq({tag, "_tx_data"},    32'(txd_m),  32'd0);
    check_eq({tag, "_resp"},       32'(resp_m), 32'd0);
  endtask

  // Response-byte gap after an anchor; favours the last legal cycle.
  function automatic int pick_gap(input int lo, input int tc);
    if ($urandom_range(0, 3) == 0) return tc - 1;
    return int'($urandom_range(lo, tc - 1));
  endfunction

  // One transaction, cycle-by-cycle. Cycle 0 is the accept cycle; with
  // pre_acc the accept happened on the previous transaction's last cycle.
  task automatic run_txn(input bit s, input logic [23:0] c, input int n_give,
                         input bit stale, input bit spam, input bit pre_acc,
                         input bit chain, input logic [23:0] next_c);
    int ncmd, nrsp, tcyc, t, sent, next_trmt, done_at, cmplt_at, rx_at, end_at, got;
    bit exp_to, fin;
    logic [15:0] exp_resp, mask;
    ncmd = s ? 3 : 2;
    nrsp = s ? 2 : 1;
    tcyc = s ? TB : TA;
    mask = s ? 16'hFFFF : 16'h00FF;
    t = pre_acc ? 1 : 0;
    sent = 0; next_trmt = 1; done_at = -1; cmplt_at = -1; rx_at = -1; end_at = -1;
    got = 0; exp_to = 1'b0; fin = 1'b0; exp_resp = '0;
    @(posedge clk); #1;
    sel = s;
    while (!fin) begin
      snd_cmd = 1'b0; tx_done = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; cmd_bus = c;
      if (t == 0) snd_cmd = 1'b1;
      if (t >= 1 && cmplt_at < 0) begin
        if (spam && $urandom_range(0, 2) == 0) begin
          snd_cmd = 1'b1; cmd_bus = 24'hFFFFFF;
        end
        if (stale && $urandom_range(0, 2) == 0) begin
          rx_rdy = 1'b1; rx_data = 8'h77;
        end
      end
      if (t == done_at) begin
        tx_done = 1'b1;
        if (sent < ncmd) next_trmt = t + 2;
        done_at = -1;
      end
      if (t == cmplt_at) begin
        if (n_give > 0) rx_at = t + pick_gap(0, tcyc);
        else begin end_at = t + tcyc; exp_to = 1'b1; end
      end
      if (t == rx_at) begin
        rx_rdy = 1'b1; rx_data = rsp_bytes[got];
        exp_resp = ((exp_resp << 8) | {8'h00, rsp_bytes[got]}) & mask;
        got++; rx_at = -1;
        if (got == nrsp) end_at = t + 1;
        else if (got < n_give) rx_at = t + 1 + pick_gap(1, tcyc);
        else begin end_at = t + 1 + tcyc; exp_to = 1'b1; end
      end
      if (chain && t == end_at) begin
        snd_cmd = 1'b1; cmd_bus = next_c;
      end

      @(negedge clk);
      check_eq("clr_rdy", 32'(clr_m), 32'(rx_rdy));
      check_eq("trmt", 32'(trmt_m), 32'(t == next_trmt));
      if (trmt_m && sent < ncmd) begin
        check_eq("tx_data", 32'(txd_m), 32'((c >> (8 * (ncmd - 1 - sent))) & 24'hFF));
        sent++; next_trmt = -1;
        done_at = t + int'($urandom_range(1, 4));
        if (sent == ncmd) cmplt_at = done_at + 1;
      end
      check_eq("cmd_cmplt", 32'(cc_m), 32'(t == cmplt_at));
      if (t == cmplt_at) check_eq("resp_cleared", 32'(resp_m), 32'd0);
      check_eq("resp_cmplt", 32'(rc_m), 32'(t == end_at && !exp_to));
      check_eq("timeout", 32'(to_m), 32'(t == end_at && exp_to));
      check_eq("busy", 32'(busy_m), 32'(t >= 1 && (end_at < 0 || t < end_at)));
      if (t == end_at) begin
        check_eq("resp", 32'(resp_m), 32'(exp_resp));
        fin = 1'b1;
      end else if (t >= 800) begin
        check_eq("txn_budget", 32'(t), 32'(end_at));
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend, ps, s, ch, st, sp;
    int          ng;
    logic [23:0] pc, c, nc;

    rst_n = 1'b0; snd_cmd = 1'b0; tx_done = 1'b0; rx_rdy = 1'b0;
    rx_data = 8'h00; cmd_bus = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst_a");
    sel = 1'b1; #1;
    check_quiet("rst_b");
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Defaults: A55A out, 3C back
    rsp_bytes[0] = 8'h3C; rsp_bytes[1] = 8'h00;
    run_txn(1'b0, 24'h00A55A, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    // Three-byte command, two-byte response
    rsp_bytes[0] = 8'hAB; rsp_bytes[1] = 8'hCD;
    run_txn(1'b1, 24'h123456, 2, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    // No response: timeout
    run_txn(1'b0, 24'h00BEEF, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    // Ignored snd_cmd while busy, then back-to-back accept on resp_cmplt
    rsp_bytes[0] = 8'h3C;
    run_txn(1'b0, 24'h00A55A, 1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h001234);
    run_txn(1'b0, 24'h001234, 1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    // Stale bytes during transmit are discarded
    run_txn(1'b0, 24'h00A55A, 1, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of TX_WAIT
    @(posedge clk); #1;
    sel = 1'b0; snd_cmd = 1'b1; cmd_bus = 24'h00A55A;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_busy", 32'(busy_m), 32'd1);
    check_eq("pre_rst_tx_data", 32'(txd_m), 32'h0000_00A5);
    check_eq("pre_rst_resp", 32'(resp_m), 32'h0000_003C);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    check_quiet("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rsp_bytes[0] = 8'h5E;
    run_txn(1'b0, 24'h00C3C3, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Randomized traffic
    pend = 1'b0; ps = 1'b0; pc = '0;
    for (int i = 0; i < 30; i++) begin
      if (pend) begin
        s = ps; c = pc;
      end else begin
        s = 1'($urandom_range(0, 1)); c = 24'($urandom);
      end
      rsp_bytes[0] = 8'($urandom);
      rsp_bytes[1] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ng = int'($urandom_range(0, s ? 1 : 0));
      else ng = s ? 2 : 1;
      st = 1'($urandom_range(0, 1));
      sp = 1'($urandom_range(0, 1));
      ch = (i < 29) && ($urandom_range(0, 2) == 0);
      nc = 24'($urandom);
      run_txn(s, c, ng, st, sp, pend, ch, nc);
      pend = ch; pc = nc; ps = s;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
